inst_prefetch_buf: RTL

- Instruction prefetch stage between the instruction ROM (inst_rom) and the fetch input of the openmips core.
- Issues sequential word addresses to the ROM and captures each returned instruction with its PC in a small FIFO.
- Presents the FIFO head to the core over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes queued entries and restarts fetch at a new PC.

---
 rtl/inst_prefetch_buf.sv | 115 +++++++++++
 1 files changed

// File: rtl/inst_prefetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_buf
// Brief    : Sequential instruction prefetcher with a small PC+instruction FIFO
//            and redirect flush. Optional perf counters: PREFETCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module inst_prefetch_buf #(
    parameter int                 DEPTH    = 4,
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              if_valid_o,
    input  logic              if_ready_i,
    output logic [DATA_W-1:0] if_inst_o,
    output logic [ADDR_W-1:0] if_pc_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_flush_o
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [DATA_W-1:0]  r_inst_mem [DEPTH];
    logic [ADDR_W-1:0]  r_pc_mem   [DEPTH];

    logic w_push;
    logic w_pop;

    // A full FIFO never issues, even if the head is popped this cycle.
    assign rom_ce_o   = !rst && !redirect_i && (r_count < c_DEPTH);
    assign rom_addr_o = r_fetch_pc;
    assign if_valid_o = (r_count != '0);

    assign w_push = rom_ce_o;
    assign w_pop  = if_valid_o && if_ready_i && !redirect_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (redirect_i) begin
            r_fetch_pc <= redirect_pc_i & ~ADDR_W'(3);
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + c_PTR_W'(1);
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is qualified by the occupancy count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[r_wr_ptr] <= rom_data_i;
            r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    assign if_inst_o = if_valid_o ? r_inst_mem[r_rd_ptr] : '0;
    assign if_pc_o   = if_valid_o ? r_pc_mem[r_rd_ptr]   : '0;

`ifdef PREFETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_push) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (redirect_i) begin
                r_perf_flush <= r_perf_flush + 32'(r_count);
            end
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_flush_o = r_perf_flush;
`else
    assign perf_fetch_o = 32'h0;
    assign perf_flush_o = 32'h0;
`endif

endmodule
`default_nettype wire
